sound_player: RTL
=================

Name: sound_player

Overview:
- Receive end of the logo sound-code interface (2-bit code_sound plus mute) driven by the bouncing-logo animation block.
- Turns each requested code into a timed square-wave tone burst on a single speaker pin.
- ping and pong are one note each. go is a two-note rising chime. stop silences immediately.
- Sits between the animation block and the board piezo/speaker pin. Single clock domain.

Parameters:
- CLK_HZ, 12000000, system clock frequency (documentation only; the counts below are absolute).
- PING_HALF, 6000, half-period in clk cycles for ping (1 kHz at 12 MHz).
- PONG_HALF, 12000, half-period for pong (500 Hz).
- GO_HALF_A, 9000, half-period of first go note (~667 Hz).
- GO_HALF_B, 4500, half-period of second go note (~1333 Hz).
- NOTE_CYCLES, 1200000, length of one note in clk cycles (100 ms).
- GAP_CYCLES, 240000, silent gap between the two go notes (20 ms).
- CNT_W, 24, width of the duration and tone counters; must hold NOTE_CYCLES.

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous active-high reset
- code_sound  in  2  requested sound: 2'b00 stop, 2'b01 pong, 2'b10 ping, 2'b11 go
- trig  in  1  one-cycle request strobe; samples code_sound in the same cycle
- mute  in  1  level; forces speaker low while high
- speaker  out  1  registered square-wave output
- busy  out  1  high while a burst (note or gap) is in progress
- cur_code  out  2  code currently playing; 2'b00 when idle

Behaviour:
- Reset (clr high at a clk edge): state IDLE, speaker=0, busy=0, cur_code=0, all counters 0. Reset wins over trig in the same cycle.
- States: IDLE, NOTE1, GAP, NOTE2.
- IDLE:
  - trig with pong/ping/go -> NOTE1 next cycle. Latch cur_code and load the half-period for that code; go uses GO_HALF_A in NOTE1.
  - trig with stop -> stays IDLE.
- NOTE1:
  - Duration counter counts 0..NOTE_CYCLES-1.
  - On the last count: pong/ping -> IDLE; go -> GAP.
- GAP:
  - Tone disabled, speaker 0, busy 1.
  - Counts GAP_CYCLES, then -> NOTE2 with GO_HALF_B.
- NOTE2:
  - Counts NOTE_CYCLES, then -> IDLE.
- Tone generation:
  - Half-period counter increments while in a NOTE state.
  - When it reaches half-1: toggle the tone bit and clear the counter.
  - Counter and tone bit are cleared on every state entry, so each note starts with speaker low for a full half-period.
- speaker:
  - Register = tone bit AND NOT mute AND (state is NOTE1 or NOTE2).
  - The effect of mute on speaker appears one cycle after mute changes.
- mute only gates the output. The FSM and timing continue, so unmuting mid-burst resumes the tone in phase.
- Retrigger while busy (latest request wins):
  - trig with a non-stop code restarts at NOTE1 with the new code; duration and tone counters cleared.
  - trig with stop aborts to IDLE next cycle: speaker=0, busy=0, cur_code=0.
- busy is high in NOTE1, GAP, NOTE2 and low in IDLE; it asserts the cycle after an accepted trig.
- code_sound is ignored when trig is low. Consecutive identical codes each need their own trig.
- Counters never wrap in legal use. Half-period values of 0 or 1 are illegal; the implementation clamps them to 2.

Decomposition:
- Shared package sound_pkg:
  - Code constants SND_STOP=2'b00, SND_PONG=2'b01, SND_PING=2'b10, SND_GO=2'b11.
  - FSM state encoding.
  - The animation block uses the same code constants.
- One sub-module, tone_gen:
  - Inputs clk, clr, en, half[CNT_W-1:0], restart; output tone.
  - Implements the half-period counter and toggle.
- sound_player holds the FSM, duration counter, code latch and output register.

Test Plan (bench overrides: PING_HALF=4, PONG_HALF=8, GO_HALF_A=6, GO_HALF_B=3, NOTE_CYCLES=100, GAP_CYCLES=20):
- Reset: clr=1 for 3 cycles with trig=1, code=go -> speaker=0, busy=0, cur_code=0 throughout and one cycle after release.
- Ping: trig with code 2'b10 ->
  - busy high for exactly 100 cycles, starting the cycle after trig.
  - speaker toggles every 4 cycles, first rise 4 cycles into the note, 12 rising edges total.
  - cur_code=2'b10 during the note, then IDLE.
- Go: trig with code 2'b11 ->
  - 100 cycles at period 12, then 20 cycles of speaker=0 with busy=1, then 100 cycles at period 6.
  - busy high 220 cycles total.
- Retrigger: ping at t0, then pong trig at t0+50 ->
  - Note restarts at period 16; busy stays high until t0+51+100.
  - cur_code changes to 2'b01 at t0+51.
- Stop abort: go, then stop trig during GAP -> next cycle state IDLE, busy=0, speaker=0, no second note.
- Mute: pong with mute held high for cycles 20-59 of the note ->
  - speaker 0 from the cycle after mute rises until the cycle after it falls.
  - Toggle phase after unmute matches an unmuted reference run.
  - busy timing is unchanged.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared sound-code vocabulary between the logo animation block and the sound player,
// plus the player's FSM encoding.
package sound_pkg;

    localparam logic [1:0] SND_STOP = 2'b00;
    localparam logic [1:0] SND_PONG = 2'b01;
    localparam logic [1:0] SND_PING = 2'b10;
    localparam logic [1:0] SND_GO   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NOTE1 = 2'd1,
        ST_GAP   = 2'd2,
        ST_NOTE2 = 2'd3
    } state_e;

    // A half-period below 2 cannot produce a square wave; force the smallest usable one.
    function automatic int unsigned clamp_half(input int unsigned h);
        return (h < 32'd2) ? 32'd2 : h;
    endfunction

endpackage

// File: rtl/sound_player_tone_gen.sv
// Square-wave generator: toggles every 'half' enabled cycles. The tone output is the
// value the tone bit takes after the coming edge, so a registered consumer stays aligned.
module tone_gen #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] half,
    input  logic             restart,
    output logic             tone
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tone_q, tone_d;

    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (restart) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (en) begin
            if (cnt_q == half - CNT_W'(1)) begin
                cnt_d  = '0;
                tone_d = ~tone_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_d;

endmodule

// File: rtl/sound_player.sv
// Turns sound-code requests from the animation block into timed square-wave bursts
// on the speaker pin: one note for ping/pong, note-gap-note chime for go.
module sound_player
    import sound_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 12000000,
    parameter int unsigned PING_HALF   = 6000,
    parameter int unsigned PONG_HALF   = 12000,
    parameter int unsigned GO_HALF_A   = 9000,
    parameter int unsigned GO_HALF_B   = 4500,
    parameter int unsigned NOTE_CYCLES = 1200000,
    parameter int unsigned GAP_CYCLES  = 240000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] code_sound,
    input  logic       trig,
    input  logic       mute,
    output logic       speaker,
    output logic       busy,
    output logic [1:0] cur_code
);

    localparam logic [CNT_W-1:0] PING_H    = CNT_W'(clamp_half(PING_HALF));
    localparam logic [CNT_W-1:0] PONG_H    = CNT_W'(clamp_half(PONG_HALF));
    localparam logic [CNT_W-1:0] GOA_H     = CNT_W'(clamp_half(GO_HALF_A));
    localparam logic [CNT_W-1:0] GOB_H     = CNT_W'(clamp_half(GO_HALF_B));
    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [1:0]       code_q, code_d;
    logic             speaker_q, speaker_d;
    logic             restart, tone_en, tone;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            dur_q     <= '0;
            half_q    <= '0;
            code_q    <= SND_STOP;
            speaker_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dur_q     <= dur_d;
            half_q    <= half_d;
            code_q    <= code_d;
            speaker_q <= speaker_d;
        end
    end

    // A trig always wins over the burst timeline: latest request replaces whatever is playing.
    always_comb begin
        state_d = state_q;
        dur_d   = dur_q + CNT_W'(1);
        half_d  = half_q;
        code_d  = code_q;
        restart = 1'b0;
        if (trig) begin
            if (code_sound == SND_STOP) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_NOTE1;
                code_d  = code_sound;
                restart = 1'b1;
                case (code_sound)
                    SND_PING: half_d = PING_H;
                    SND_PONG: half_d = PONG_H;
                    default:  half_d = GOA_H;
                endcase
            end
        end else begin
            case (state_q)
                ST_NOTE1: if (dur_q == NOTE_LAST)
                              state_d = (code_q == SND_GO) ? ST_GAP : ST_IDLE;
                ST_GAP: if (dur_q == GAP_LAST) begin
                            state_d = ST_NOTE2;
                            half_d  = GOB_H;
                        end
                ST_NOTE2: if (dur_q == NOTE_LAST) state_d = ST_IDLE;
                default: ;
            endcase
        end
        if (state_d != state_q) restart = 1'b1;
        if (state_d == ST_IDLE) code_d = SND_STOP;
        if (restart || state_d == ST_IDLE) dur_d = '0;
    end

    // speaker is registered from next-cycle values so a note opens with a full low half-period.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        cur_code  = code_q;
        speaker   = speaker_q;
        tone_en   = (state_q == ST_NOTE1) || (state_q == ST_NOTE2);
        speaker_d = tone && !mute && ((state_d == ST_NOTE1) || (state_d == ST_NOTE2));
    end

    tone_gen #(.CNT_W(CNT_W)) u_tone (
        .clk     (clk),
        .clr     (clr),
        .en      (tone_en),
        .half    (half_q),
        .restart (restart),
        .tone    (tone)
    );

endmodule
